// File: rtl/laser_pulse_gen.sv
// Laser pulse generator: programmable width/period pulse train with a fail-driven HALT.
// Define LASER_PULSE_GEN_BURST_EN to stop after burst_count pulses and strobe burst_done.
module laser_pulse_gen #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enable,
   input  logic [31:0]      pulse_width,
   input  logic [31:0]      pulse_period,
   input  logic [15:0]      burst_count,
   input  logic             fail_any,
   input  logic             clear_fail,
   output logic             laser_pulse,
   output logic             busy,
   output logic             fault_stop,
   output logic             cfg_error,
   output logic             burst_done,
   output logic [CNT_W-1:0] pulse_count
);
   // state | meaning
   // IDLE  | laser off, waiting for enable with a valid config
   // HIGH  | laser on for the latched pulse width
   // LOW   | laser off for the remainder of the latched period
   // HALT  | laser forced off by fail_any, waiting for clear_fail
   typedef enum logic [1:0] {IDLE, HIGH, LOW, HALT} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] low_len_q;
   logic [CNT_W-1:0] pulse_count_q;
   logic             laser_q;
   logic             busy_q;
   logic             fault_q;
   logic             cfg_err_q;

   logic             cfg_valid;
   logic [CNT_W-1:0] width_ld;
   logic [CNT_W-1:0] low_ld;
   logic [CNT_W-1:0] count_inc;
   logic             low_end;
   logic             go_start;
   logic             go_next;
   logic             burst_last;
   logic             rearm_block;

   // Period > width guarantees the subtraction below never underflows.
   assign cfg_valid = (pulse_width != 32'd0) && (pulse_period > pulse_width);
   assign width_ld  = CNT_W'(pulse_width - 32'd1);
   assign low_ld    = CNT_W'(pulse_period - pulse_width - 32'd1);
   assign count_inc = (&pulse_count_q) ? pulse_count_q : pulse_count_q + CNT_W'(1);

   assign low_end  = (state_q == LOW) && (cnt_q == '0) && !fail_any;
   assign go_start = (state_q == IDLE) && enable && cfg_valid && !rearm_block && !fail_any;
   assign go_next  = low_end && !burst_last && enable && cfg_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         low_len_q     <= '0;
         pulse_count_q <= '0;
         laser_q       <= 1'b0;
         busy_q        <= 1'b0;
         fault_q       <= 1'b0;
         cfg_err_q     <= 1'b0;
      end else begin
         cfg_err_q <= !cfg_valid;
         if (fail_any) begin
            state_q <= HALT;
            laser_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  if (go_start) begin
                     state_q       <= HIGH;
                     laser_q       <= 1'b1;
                     busy_q        <= 1'b1;
                     cnt_q         <= width_ld;
                     low_len_q     <= low_ld;
                     pulse_count_q <= CNT_W'(1);
                  end
               end
               HIGH: begin
                  if (cnt_q == '0) begin
                     state_q <= LOW;
                     laser_q <= 1'b0;
                     cnt_q   <= low_len_q;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               LOW: begin
                  if (cnt_q != '0) begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end else if (go_next) begin
                     state_q       <= HIGH;
                     laser_q       <= 1'b1;
                     cnt_q         <= width_ld;
                     low_len_q     <= low_ld;
                     pulse_count_q <= count_inc;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               HALT: begin
                  if (clear_fail) begin
                     state_q <= IDLE;
                     fault_q <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

`ifdef LASER_PULSE_GEN_BURST_EN
   logic [15:0] burst_left_q;
   logic        rearm_q;
   logic        done_q;

   // burst_left_q counts pulses still owed including the current one; 0 means continuous.
   assign burst_last  = (burst_left_q == 16'd1);
   assign rearm_block = rearm_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         burst_left_q <= 16'd0;
         rearm_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= low_end && burst_last;
         if (go_start)
            burst_left_q <= burst_count;
         else if (go_next && (burst_left_q != 16'd0))
            burst_left_q <= burst_left_q - 16'd1;
         if (low_end && burst_last)
            rearm_q <= 1'b1;
         else if (!enable)
            rearm_q <= 1'b0;
      end
   end

   assign burst_done = done_q;
`else
   logic burst_count_unused;

   assign burst_count_unused = ^burst_count;
   assign burst_last         = 1'b0;
   assign rearm_block        = 1'b0;
   assign burst_done         = 1'b0;
`endif

   assign laser_pulse = laser_q;
   assign busy        = busy_q;
   assign fault_stop  = fault_q;
   assign cfg_error   = cfg_err_q;
   assign pulse_count = pulse_count_q;

endmodule
